queue_arbiter: RTL and testbench

- Controller that shares the 8-entry byte queue between two producers (A, B) and one consumer.
- Converts level-held requests into single-cycle enqueue/dequeue strobes toward the queue.
- Waits a fixed settle time after each strobe, then returns a one-cycle ack (and read data for dequeues).
- Sits between the requesters and the queue, all on clock_10KHZ.

---
 rtl/queue_pkg.sv | 12 +
 rtl/queue_arb_pick.sv | 43 ++++
 rtl/queue_arbiter.sv | 129 ++++++++++++
 tb/tb_queue_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared types for the two-producer / one-consumer byte-queue arbiter.
package queue_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESPOND} arb_state_t;
  typedef enum logic [1:0] {OP_ENQ_A, OP_ENQ_B, OP_DEQ} arb_op_t;
  typedef enum logic {CLASS_ENQ, CLASS_DEQ} arb_class_t;
  typedef enum logic {PROD_A, PROD_B} prod_t;

  localparam int QUEUE_DEPTH = 8;
  localparam int LEN_W = 4;

endpackage

// File: rtl/queue_arb_pick.sv
// Combinational eligibility check plus class and producer selection.
module queue_arb_pick
  import queue_pkg::*;
#(
  parameter int FULL_LEVEL = 7
) (
  input  logic             prod_a_req,
  input  logic             prod_b_req,
  input  logic             cons_req,
  input  logic [LEN_W-1:0] q_len,
  input  prod_t            rr,
  input  arb_class_t       last_class,
  output logic             grant,
  output arb_op_t          op
);

  logic    enq_ok;
  logic    deq_ok;
  arb_op_t enq_op;

  always_comb begin
    enq_ok = (prod_a_req | prod_b_req) && (q_len < LEN_W'(FULL_LEVEL));
    deq_ok = cons_req && (q_len != '0);

    if (prod_a_req && prod_b_req) begin
      enq_op = (rr == PROD_A) ? OP_ENQ_A : OP_ENQ_B;
    end else if (prod_a_req) begin
      enq_op = OP_ENQ_A;
    end else begin
      enq_op = OP_ENQ_B;
    end

    grant = enq_ok | deq_ok;
    op    = OP_DEQ;
    // When both classes compete, serve the one that did not go last.
    if (enq_ok && deq_ok) begin
      op = (last_class == CLASS_DEQ) ? enq_op : OP_DEQ;
    end else if (enq_ok) begin
      op = enq_op;
    end
  end

endmodule

// File: rtl/queue_arbiter.sv
// Shares one byte queue between producers A/B and a consumer: one strobe per
// operation, a fixed settle wait, then a single-cycle ack.
module queue_arbiter
  import queue_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3,
  parameter int FULL_LEVEL    = 7,
  parameter int DATA_W        = 8
) (
  input  logic              clock_10KHZ,
  input  logic              reset,
  input  logic              prod_a_req,
  input  logic [DATA_W-1:0] prod_a_data,
  output logic              prod_a_ack,
  input  logic              prod_b_req,
  input  logic [DATA_W-1:0] prod_b_data,
  output logic              prod_b_ack,
  input  logic              cons_req,
  output logic              cons_ack,
  output logic [DATA_W-1:0] cons_data,
  output logic [DATA_W-1:0] q_data_in,
  output logic              q_enqueue,
  output logic              q_dequeue,
  input  logic [LEN_W-1:0]  q_len,
  input  logic [DATA_W-1:0] q_data_out,
  output logic              full,
  output logic              empty
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_t        state_reg;
  arb_state_t        state_next;
  arb_op_t           op_reg;
  prod_t             rr_reg;
  arb_class_t        last_class_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] data_in_reg;
  logic [DATA_W-1:0] cons_data_reg;
  logic              grant;
  arb_op_t           pick_op;
  logic              settle_done;

  queue_arb_pick #(
    .FULL_LEVEL(FULL_LEVEL)
  ) u_pick (
    .prod_a_req(prod_a_req),
    .prod_b_req(prod_b_req),
    .cons_req  (cons_req),
    .q_len     (q_len),
    .rr        (rr_reg),
    .last_class(last_class_reg),
    .grant     (grant),
    .op        (pick_op)
  );

  assign settle_done = (cnt_reg == CNT_W'(SETTLE_CYCLES - 1));
  assign full        = (q_len >= LEN_W'(FULL_LEVEL));
  assign empty       = (q_len == '0);
  assign q_data_in   = data_in_reg;
  assign cons_data   = cons_data_reg;

  always_comb begin
    state_next = state_reg;
    q_enqueue  = 1'b0;
    q_dequeue  = 1'b0;
    prod_a_ack = 1'b0;
    prod_b_ack = 1'b0;
    cons_ack   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant) state_next = ISSUE;
      end
      ISSUE: begin
        q_enqueue  = (op_reg != OP_DEQ);
        q_dequeue  = (op_reg == OP_DEQ);
        state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_done) state_next = RESPOND;
      end
      RESPOND: begin
        prod_a_ack = (op_reg == OP_ENQ_A);
        prod_b_ack = (op_reg == OP_ENQ_B);
        cons_ack   = (op_reg == OP_DEQ);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_10KHZ or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      op_reg         <= OP_DEQ;
      rr_reg         <= PROD_A;
      last_class_reg <= CLASS_DEQ;
      cnt_reg        <= '0;
      data_in_reg    <= '0;
      cons_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant) begin
            op_reg <= pick_op;
            // The pointer always moves to the producer not just chosen.
            if (pick_op == OP_ENQ_A) begin
              data_in_reg <= prod_a_data;
              rr_reg      <= PROD_B;
            end else if (pick_op == OP_ENQ_B) begin
              data_in_reg <= prod_b_data;
              rr_reg      <= PROD_A;
            end
          end
        end
        ISSUE: cnt_reg <= '0;
        SETTLE: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          // Capture read data on the edge that enters RESPOND.
          if (settle_done && (op_reg == OP_DEQ)) cons_data_reg <= q_data_out;
        end
        RESPOND: last_class_reg <= (op_reg == OP_DEQ) ? CLASS_DEQ : CLASS_ENQ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter: per-cycle vector table plus hand sequences.
module tb_queue_arbiter;

  logic       clk;
  logic       rst;
  logic       a_req, b_req, c_req;
  logic [7:0] a_data, b_data;
  logic [3:0] q_len;
  logic [7:0] q_dout;
  logic       prod_a_ack, prod_b_ack, cons_ack, q_enqueue, q_dequeue, full, empty;
  logic [7:0] cons_data, q_data_in;

  logic       c1_req;
  logic [7:0] zero8;
  logic       zero1;
  logic [3:0] q_len1;
  logic [7:0] q_dout1;
  logic       prod_a_ack1, prod_b_ack1, cons_ack1, q_enqueue1, q_dequeue1, full1, empty1;
  logic [7:0] cons_data1, q_data_in1;

  queue_arbiter u_dut (
    .clock_10KHZ(clk), .reset(rst),
    .prod_a_req(a_req), .prod_a_data(a_data), .prod_a_ack(prod_a_ack),
    .prod_b_req(b_req), .prod_b_data(b_data), .prod_b_ack(prod_b_ack),
    .cons_req(c_req), .cons_ack(cons_ack), .cons_data(cons_data),
    .q_data_in(q_data_in), .q_enqueue(q_enqueue), .q_dequeue(q_dequeue),
    .q_len(q_len), .q_data_out(q_dout), .full(full), .empty(empty)
  );

  queue_arbiter #(.SETTLE_CYCLES(1)) u_dut1 (
    .clock_10KHZ(clk), .reset(rst),
    .prod_a_req(zero1), .prod_a_data(zero8), .prod_a_ack(prod_a_ack1),
    .prod_b_req(zero1), .prod_b_data(zero8), .prod_b_ack(prod_b_ack1),
    .cons_req(c1_req), .cons_ack(cons_ack1), .cons_data(cons_data1),
    .q_data_in(q_data_in1), .q_enqueue(q_enqueue1), .q_dequeue(q_dequeue1),
    .q_len(q_len1), .q_data_out(q_dout1), .full(full1), .empty(empty1)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       a;   logic [7:0] ad;
    logic       b;   logic [7:0] bd;
    logic       c;   logic [3:0] ql;  logic [7:0] qd;
    logic       enq; logic       deq; logic [7:0] din;
    logic       aa;  logic       ba;  logic       ca;
    logic [7:0] cd;  logic       fl;  logic       em;
  } vec_t;

  vec_t       tbl[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] mq[$];
  logic [7:0] mdout;
  int         exp_ops[$];
  int         exp_cons[$];

  function automatic vec_t mk(int a, int ad, int b, int bd, int c, int ql, int qd,
                              int enq, int deq, int din, int aa, int ba, int ca,
                              int cd, int fl, int em);
    vec_t v;
    v.a = 1'(a);     v.ad = 8'(ad);  v.b = 1'(b);   v.bd = 8'(bd);
    v.c = 1'(c);     v.ql = 4'(ql);  v.qd = 8'(qd);
    v.enq = 1'(enq); v.deq = 1'(deq); v.din = 8'(din);
    v.aa = 1'(aa);   v.ba = 1'(ba);  v.ca = 1'(ca);
    v.cd = 8'(cd);   v.fl = 1'(fl);  v.em = 1'(em);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock; the external queue model applies strobes sampled before the edge.
  task automatic tick();
    logic       e, d;
    logic [7:0] din;
    e = q_enqueue; d = q_dequeue; din = q_data_in;
    @(posedge clk); #1;
    if (e) mq.push_back(din);
    if (d && mq.size() > 0) mdout = mq.pop_front();
    q_len  = 4'(mq.size());
    q_dout = mdout;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
    mq.delete(); mdout = 8'h00; q_len = 4'd0; q_dout = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  // Ops: 0 = ENQ_A, 1 = ENQ_B, 2 = DEQ.
  task automatic run_seq(input string tag, input logic ha, input logic hb, input logic hc,
                         input int budget);
    int         served, strobe_cyc, last_ack, cur, ci, cyc;
    logic [2:0] exp_ack;
    served = 0; strobe_cyc = -1; last_ack = -1; cur = 0; ci = 0; cyc = 0;
    a_req = ha; b_req = hb; c_req = hc;
    while (served < exp_ops.size() && cyc < budget) begin
      tick();
      cyc++;
      if (q_enqueue || q_dequeue) begin
        cur = exp_ops[served];
        chk({tag, " strobe kind"}, 32'({q_enqueue, q_dequeue}), (cur == 2) ? 32'h1 : 32'h2);
        if (cur != 2)
          chk({tag, " q_data_in"}, 32'(q_data_in), 32'((cur == 0) ? a_data : b_data));
        if (last_ack >= 0) chk({tag, " strobe gap"}, 32'(cyc - last_ack), 32'd2);
        strobe_cyc = cyc;
      end
      exp_ack = (strobe_cyc >= 0 && cyc == strobe_cyc + 4) ? (3'b100 >> cur) : 3'b000;
      chk({tag, " acks"}, 32'({prod_a_ack, prod_b_ack, cons_ack}), 32'(exp_ack));
      if (exp_ack != 3'b000) begin
        if (cur == 2) begin
          chk({tag, " cons_data"}, 32'(cons_data), 32'(exp_cons[ci]));
          ci++;
        end
        $display("%s: op %0d acked at cycle %0d cons_data 0x%0h", tag, cur, cyc, cons_data);
        last_ack = cyc; strobe_cyc = -1; served++;
      end
    end
    if (served < exp_ops.size()) begin
      n_vec++; n_bad++;
      $display("FAIL %s timeout: served %0d, want %0d", tag, served, exp_ops.size());
    end
    tick();
    a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
    tick();
    chk({tag, " idle after drop"}, 32'({q_enqueue, q_dequeue}), 32'h0);
  endtask

  initial begin
    logic found;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
    a_data = 8'h00; b_data = 8'h00; q_len = 4'd0; q_dout = 8'h00; mdout = 8'h00;
    c1_req = 1'b0; zero8 = 8'h00; zero1 = 1'b0; q_len1 = 4'd0; q_dout1 = 8'h00;

    //      a  ad    b bd c ql qd     enq deq din  aa ba ca cd   full empty
    tbl.push_back(mk(1, 'hA5, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,     0, 1));
    tbl.push_back(mk(1, 'hA5, 0, 0, 0, 0, 0,     1, 0, 'hA5,  0, 0, 0, 0,     0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 'hA5, 0, 0, 0, 1, 0,   0, 0, 0,     0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(1, 'hA5, 0, 0, 0, 1, 0,     0, 0, 0,     1, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 1, 0,     0, 0, 0,     0, 0, 0, 0,     0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 'h33, 0, 0, 0, 7, 0,   0, 0, 0,     0, 0, 0, 0,     1, 0));
    tbl.push_back(mk(1, 'h33, 0, 0, 0, 6, 0,     0, 0, 0,     0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(1, 'h33, 0, 0, 0, 6, 0,     1, 0, 'h33,  0, 0, 0, 0,     0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 'h33, 0, 0, 0, 7, 0,   0, 0, 0,     0, 0, 0, 0,     1, 0));
    tbl.push_back(mk(1, 'h33, 0, 0, 0, 7, 0,     0, 0, 0,     1, 0, 0, 0,     1, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 7, 0,     0, 0, 0,     0, 0, 0, 0,     1, 0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0, 0,  0, 0, 1, 0, 0,     0, 0, 0,     0, 0, 0, 0,     0, 1));
    tbl.push_back(mk(1, 'h44, 0, 0, 1, 0, 0,     0, 0, 0,     0, 0, 0, 0,     0, 1));
    tbl.push_back(mk(1, 'h44, 0, 0, 1, 0, 0,     1, 0, 'h44,  0, 0, 0, 0,     0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 'h44, 0, 0, 1, 1, 'h44, 0, 0, 0,    0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(1, 'h44, 0, 0, 1, 1, 'h44,  0, 0, 0,     1, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 1, 'h44,  0, 0, 0,     0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 1, 'h44,  0, 1, 0,     0, 0, 0, 0,     0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0,  0, 0, 1, 0, 'h44,  0, 0, 0,     0, 0, 0, 0,     0, 1));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0, 'h44,  0, 0, 0,     0, 0, 1, 'h44,  0, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 'h44,  0, 1));

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset strobes", 32'({q_enqueue, q_dequeue}), 32'h0);
    chk("reset acks", 32'({prod_a_ack, prod_b_ack, cons_ack}), 32'h0);
    chk("reset q_data_in", 32'(q_data_in), 32'h0);
    chk("reset cons_data", 32'(cons_data), 32'h0);
    chk("reset full/empty", 32'({full, empty}), 32'h1);
    chk("reset dut1 outputs", 32'({q_enqueue1, q_dequeue1, prod_a_ack1, prod_b_ack1, cons_ack1,
                                   full1, empty1}), 32'h1);
    chk("reset dut1 data", 32'({q_data_in1, cons_data1}), 32'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      a_req = tbl[i].a; a_data = tbl[i].ad; b_req = tbl[i].b; b_data = tbl[i].bd;
      c_req = tbl[i].c; q_len = tbl[i].ql;  q_dout = tbl[i].qd;
      #1;
      chk($sformatf("row%0d q_enqueue", i), 32'(q_enqueue), 32'(tbl[i].enq));
      chk($sformatf("row%0d q_dequeue", i), 32'(q_dequeue), 32'(tbl[i].deq));
      if (tbl[i].enq) chk($sformatf("row%0d q_data_in", i), 32'(q_data_in), 32'(tbl[i].din));
      chk($sformatf("row%0d acks", i), 32'({prod_a_ack, prod_b_ack, cons_ack}),
          32'({tbl[i].aa, tbl[i].ba, tbl[i].ca}));
      chk($sformatf("row%0d cons_data", i), 32'(cons_data), 32'(tbl[i].cd));
      chk($sformatf("row%0d full/empty", i), 32'({full, empty}), 32'({tbl[i].fl, tbl[i].em}));
    end

    // Round-robin between two held producers
    do_reset();
    a_data = 8'h11; b_data = 8'h22;
    exp_ops = '{0, 1, 0, 1};
    exp_cons.delete();
    run_seq("rr", 1'b1, 1'b1, 1'b0, 40);

    // Enqueue/dequeue alternation from length 3
    do_reset();
    mq.push_back(8'h10); mq.push_back(8'h20); mq.push_back(8'h30);
    q_len = 4'd3;
    a_data = 8'h5A;
    exp_ops  = '{0, 2, 0, 2, 0, 2};
    exp_cons = '{8'h10, 8'h20, 8'h30};
    run_seq("alt", 1'b1, 1'b0, 1'b1, 60);

    // Reset during the second SETTLE cycle of ENQ_B
    chk("rst cons_data before", 32'(cons_data), 32'h30);
    b_data = 8'hB7; b_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (q_enqueue) found = 1'b1;
    end
    chk("rst strobe seen", 32'(found), 32'h1);
    chk("rst strobe data", 32'(q_data_in), 32'hB7);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst async strobes/acks", 32'({q_enqueue, q_dequeue, prod_a_ack, prod_b_ack, cons_ack}), 32'h0);
    chk("rst async data", 32'({q_data_in, cons_data}), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst no b_ack", 32'(prod_b_ack), 32'h0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("rst-rerun c%0d enq", i), 32'(q_enqueue), 32'(i == 1));
      chk($sformatf("rst-rerun c%0d b_ack", i), 32'(prod_b_ack), 32'(i == 5));
      if (i == 1) chk("rst-rerun data", 32'(q_data_in), 32'hB7);
    end
    $display("rst: ENQ_B re-run completed after reset");
    b_req = 1'b0;
    tick();

    // SETTLE_CYCLES=1 instance: single dequeue
    c1_req = 1'b1; q_len1 = 4'd1; q_dout1 = 8'h9C;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("s1 c%0d deq", i), 32'(q_dequeue1), 32'(i == 1));
      chk($sformatf("s1 c%0d cons_ack", i), 32'(cons_ack1), 32'(i == 3));
      chk($sformatf("s1 c%0d other", i), 32'({q_enqueue1, prod_a_ack1, prod_b_ack1}), 32'h0);
      if (i == 3) begin
        chk("s1 cons_data", 32'(cons_data1), 32'h9C);
        $display("s1: DEQ acked with cons_data 0x%0h", cons_data1);
      end
      if (i == 4) c1_req = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
